xbar_slave_arbiter: RTL

Per-slave round-robin arbiter for the crossbar. It sits between NM per-master address decoders (each presenting valid plus a one-hot NS+1 decode, bit NS meaning "no slave") and the NS slave ports. It grants each slave to at most one master, holds the grant while that master has responses outstanding, and tracks per-master outstanding counts so masters can switch slaves without losing acknowledgements.

---
 rtl/xbar_slave_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/xbar_slave_arbiter.sv
// Per-slave round-robin arbiter for the crossbar.
// Each real slave is owned by at most one master. A grant is held while
// that master has responses outstanding, and every master can hold at most
// one grant. The "no slave" target (decode bit NS) is shared by everyone.
module xbar_slave_arbiter #(
    parameter  int NM         = 4,
    parameter  int NS         = 8,
    parameter  int LGMAXBURST = 5,
    localparam int LGNS       = $clog2(NS+1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NM-1:0]        i_mcyc,
    input  logic [NM-1:0]        i_mvalid,
    input  logic [NM*(NS+1)-1:0] i_mdecode,
    input  logic [NM-1:0]        i_maccept,
    input  logic [NM-1:0]        i_mack,
    output logic [NM-1:0]        o_mgrant,
    output logic [NM*LGNS-1:0]   o_mindex,
    output logic [NS*NM-1:0]     o_sgrant,
    output logic [NM-1:0]        o_mfull,
    output logic [NM-1:0]        o_mempty
);
    localparam int                    LGNM    = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [LGMAXBURST-1:0] CNT_MAX = '1;
    localparam logic [LGNS-1:0]       NOSLV   = LGNS'(NS);

    logic [NM-1:0]         mgrant_q, mgrant_d;
    logic [LGNS-1:0]       mindex_q [NM];
    logic [LGNS-1:0]       mindex_d [NM];
    logic [NM-1:0]         sgrant_q [NS];
    logic [NM-1:0]         sgrant_d [NS];
    logic [LGMAXBURST-1:0] cnt_q    [NM];
    logic [LGMAXBURST-1:0] cnt_d    [NM];
    logic [LGNM-1:0]       ptr_q    [NS];
    logic [LGNM-1:0]       ptr_d    [NS];

    logic [NS:0]           mdec     [NM];
    logic [NM-1:0]         mreq;
    logic [LGNS-1:0]       mreq_idx [NM];
    logic [NM-1:0]         mother;
    logic [NM-1:0]         mrel;

    // Decode each master's request target and whether it must give up its grant
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            mdec[m]     = i_mdecode[m*(NS+1) +: NS+1];
            mreq_idx[m] = '0;
            mother[m]   = 1'b0;
            // Lowest set bit wins should a decoder ever present more than one
            for (int s = NS; s >= 0; s--) begin
                if (mdec[m][s]) begin
                    mreq_idx[m] = LGNS'(s);
                end
            end
            for (int s = 0; s <= NS; s++) begin
                if (mdec[m][s] && (LGNS'(s) != mindex_q[m])) begin
                    mother[m] = 1'b1;
                end
            end
            mreq[m] = i_mcyc[m] && i_mvalid[m] && (|mdec[m]) && !mgrant_q[m];
            // Abort drops at once; a slave switch waits for the counter to drain
            mrel[m] = mgrant_q[m] &&
                      (!i_mcyc[m] || (i_mvalid[m] && mother[m] && (cnt_q[m] == '0)));
        end
    end

    // Release grants, then arbitrate slaves that were free at the start of the cycle
    always_comb begin
        int   cand;
        logic found;
        mgrant_d = mgrant_q;
        mindex_d = mindex_q;
        sgrant_d = sgrant_q;
        ptr_d    = ptr_q;
        cand     = 0;
        found    = 1'b0;
        for (int m = 0; m < NM; m++) begin
            if (mrel[m]) begin
                mgrant_d[m] = 1'b0;
                for (int s = 0; s < NS; s++) begin
                    sgrant_d[s][m] = 1'b0;
                end
            end
        end
        // A slave freed this cycle still shows its owner in sgrant_q, so it
        // only becomes available to the arbiter on the following cycle.
        for (int s = 0; s < NS; s++) begin
            found = 1'b0;
            if (sgrant_q[s] == '0) begin
                for (int k = 0; k < NM; k++) begin
                    cand = (int'(ptr_q[s]) + k) % NM;
                    if (!found && mreq[cand] && (mreq_idx[cand] == LGNS'(s))) begin
                        found          = 1'b1;
                        sgrant_d[s]    = '0;
                        sgrant_d[s][cand] = 1'b1;
                        mgrant_d[cand] = 1'b1;
                        mindex_d[cand] = LGNS'(s);
                        ptr_d[s]       = LGNM'((cand + 1) % NM);
                    end
                end
            end
        end
        // The error target is shared: every requester gets it
        for (int m = 0; m < NM; m++) begin
            if (mreq[m] && (mreq_idx[m] == NOSLV)) begin
                mgrant_d[m] = 1'b1;
                mindex_d[m] = NOSLV;
            end
        end
    end

    // Outstanding response counters; a dropped bus cycle abandons everything
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            cnt_d[m] = cnt_q[m];
            if (!i_mcyc[m]) begin
                cnt_d[m] = '0;
            end else if (i_maccept[m] && !i_mack[m] && (cnt_q[m] != CNT_MAX)) begin
                cnt_d[m] = cnt_q[m] + LGMAXBURST'(1);
            end else if (i_mack[m] && !i_maccept[m] && (cnt_q[m] != '0)) begin
                cnt_d[m] = cnt_q[m] - LGMAXBURST'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mgrant_q <= '0;
            for (int m = 0; m < NM; m++) begin
                mindex_q[m] <= '0;
                cnt_q[m]    <= '0;
            end
            for (int s = 0; s < NS; s++) begin
                sgrant_q[s] <= '0;
                ptr_q[s]    <= '0;
            end
        end else begin
            mgrant_q <= mgrant_d;
            mindex_q <= mindex_d;
            sgrant_q <= sgrant_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    // Flatten registered state onto the output ports
    always_comb begin
        o_mgrant = mgrant_q;
        for (int m = 0; m < NM; m++) begin
            o_mindex[m*LGNS +: LGNS] = mindex_q[m];
            o_mfull[m]  = (cnt_q[m] == CNT_MAX);
            o_mempty[m] = (cnt_q[m] == '0);
        end
        for (int s = 0; s < NS; s++) begin
            o_sgrant[s*NM +: NM] = sgrant_q[s];
        end
    end

`ifdef FORMAL
    // Accepting into a full counter or acking an empty one is a master bug
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int m = 0; m < NM; m++) begin
                if (i_mcyc[m]) begin
                    assert (!(i_maccept[m] && !i_mack[m] && o_mfull[m]));
                    assert (!(i_mack[m] && !i_maccept[m] && o_mempty[m]));
                end
            end
        end
    end
`endif

endmodule
